// File: rtl/jdeser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jdeser_pkg
// Description : Shared types and constants for the jdeserializer receive
//               stage: FSM state encoding, start/stop bit levels and the
//               bit-counter width helper.
// Config      : JDESER_PARITY_EN (consumed by jdeserializer)
// Revision    : 1.0 - initial release
// ============================================================================
package jdeser_pkg;

   // Receive FSM states; PARITY is only reachable when parity is compiled in
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } jdeser_state_t;

   localparam logic JDESER_START_BIT = 1'b0;
   localparam logic JDESER_STOP_BIT  = 1'b1;

   // Width of a counter able to hold the values 0..width
   function automatic int jdeser_cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage : jdeser_pkg
`default_nettype wire

// File: rtl/jshiftreg.sv
`default_nettype none
// ============================================================================
// Module      : jshiftreg
// Description : WIDTH-bit right-shift register. New bits enter at the MSB,
//               so after WIDTH shifts the first bit sits at bit 0.
// Revision    : 1.0 - initial release
// ============================================================================
module jshiftreg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift_en_i,
   input  logic             bit_i,
   output logic [WIDTH-1:0] data_o
);

   logic [WIDTH-1:0] r_data_q;

   generate
      if (WIDTH == 1) begin : g_single
         // Single-bit register: the shift degenerates to a load
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_data_q <= '0;
            end else if (shift_en_i) begin
               r_data_q <= bit_i;
            end
         end
      end else begin : g_multi
         // Right shift with the new bit entering at the MSB end
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_data_q <= '0;
            end else if (shift_en_i) begin
               r_data_q <= {bit_i, r_data_q[WIDTH-1:1]};
            end
         end
      end
   endgenerate

   assign data_o = r_data_q;

endmodule : jshiftreg
`default_nettype wire

// File: rtl/jdeserializer.sv
`default_nettype none
// ============================================================================
// Module      : jdeserializer
// Description : Serial-to-parallel receive stage. Detects a start bit,
//               shifts in WIDTH data bits LSB first, optionally checks an
//               even-parity bit, validates the stop bit and presents the word
//               on a valid/ready handshake.
// Config      : JDESER_PARITY_EN - when defined, a parity bit follows the
//               data bits and parity_err is live; otherwise parity_err = 0.
// Revision    : 1.0 - initial release
// ============================================================================
module jdeserializer
   import jdeser_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             sin_valid,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             busy,
   output logic             frame_err,
   output logic             parity_err,
   output logic             overrun
);

   localparam int            CW     = jdeser_cnt_width(WIDTH);
   localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

   jdeser_state_t    r_state_q;
   logic [CW-1:0]    r_cnt_q;
   logic [WIDTH-1:0] r_dout_q;
   logic             r_dout_valid_q;
   logic             r_busy_q;
   logic             r_frame_err_q;
   logic             r_overrun_q;

   logic [WIDTH-1:0] w_word;
   logic             w_shift_en;
   logic             w_slot_free;

   // Only qualified bits taken while in DATA reach the shift register
   assign w_shift_en  = sin_valid && (r_state_q == ST_DATA);
   // Slot can take a new word if empty or being drained on this edge
   assign w_slot_free = !r_dout_valid_q || dout_ready;

   jshiftreg #(
      .WIDTH (WIDTH)
   ) u_shiftreg (
      .clk        (clk),
      .rst        (rst),
      .shift_en_i (w_shift_en),
      .bit_i      (sin),
      .data_o     (w_word)
   );

`ifdef JDESER_PARITY_EN
   logic r_par_bad_q;
   logic r_parity_err_q;
`endif

   // Receive FSM with bit counter, output slot and registered status pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state_q      <= ST_IDLE;
         r_cnt_q        <= '0;
         r_dout_q       <= '0;
         r_dout_valid_q <= 1'b0;
         r_busy_q       <= 1'b0;
         r_frame_err_q  <= 1'b0;
         r_overrun_q    <= 1'b0;
`ifdef JDESER_PARITY_EN
         r_par_bad_q    <= 1'b0;
         r_parity_err_q <= 1'b0;
`endif
      end else begin
         r_frame_err_q <= 1'b0;
         r_overrun_q   <= 1'b0;
`ifdef JDESER_PARITY_EN
         r_parity_err_q <= 1'b0;
`endif
         // Consumer handshake; a word loaded below on the same edge overrides
         if (r_dout_valid_q && dout_ready) begin
            r_dout_valid_q <= 1'b0;
         end

         case (r_state_q)
            ST_IDLE: begin
               if (sin_valid && (sin == JDESER_START_BIT)) begin
                  r_state_q <= ST_DATA;
                  r_cnt_q   <= '0;
                  r_busy_q  <= 1'b1;
`ifdef JDESER_PARITY_EN
                  r_par_bad_q <= 1'b0;
`endif
               end
            end

            ST_DATA: begin
               if (sin_valid) begin
                  r_cnt_q <= r_cnt_q + 1'b1;
                  if (r_cnt_q == C_LAST) begin
`ifdef JDESER_PARITY_EN
                     r_state_q <= ST_PARITY;
`else
                     r_state_q <= ST_STOP;
`endif
                  end
               end
            end

`ifdef JDESER_PARITY_EN
            ST_PARITY: begin
               if (sin_valid) begin
                  // Even parity: data bits plus parity bit must XOR to 0
                  r_par_bad_q <= (^w_word) ^ sin;
                  r_state_q   <= ST_STOP;
               end
            end
`endif

            ST_STOP: begin
               if (sin_valid) begin
                  r_state_q <= ST_IDLE;
                  r_busy_q  <= 1'b0;
                  if (sin != JDESER_STOP_BIT) begin
                     r_frame_err_q <= 1'b1;
`ifdef JDESER_PARITY_EN
                  end else if (r_par_bad_q) begin
                     r_parity_err_q <= 1'b1;
`endif
                  end else if (w_slot_free) begin
                     r_dout_q       <= w_word;
                     r_dout_valid_q <= 1'b1;
                  end else begin
                     r_overrun_q <= 1'b1;
                  end
               end
            end

            default: begin
               r_state_q <= ST_IDLE;
               r_busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign dout       = r_dout_q;
   assign dout_valid = r_dout_valid_q;
   assign busy       = r_busy_q;
   assign frame_err  = r_frame_err_q;
   assign overrun    = r_overrun_q;
`ifdef JDESER_PARITY_EN
   assign parity_err = r_parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule : jdeserializer
`default_nettype wire

// File: tb/tb_jdeserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_jdeserializer
// Description : Self-checking bench for jdeserializer (WIDTH = 8). A table of
//               frames with hand-computed results, followed by directed
//               sequences for reset, idle, gap and back-to-back behaviour.
//               Parity vectors are added when JDESER_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jdeserializer;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             sin;
   logic             sin_valid;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             dout_ready;
   logic             busy;
   logic             frame_err;
   logic             parity_err;
   logic             overrun;

   int n_vec  = 0;
   int n_fail = 0;

   jdeserializer #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .sin        (sin),
      .sin_valid  (sin_valid),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .busy       (busy),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       par;
      logic       gap;
      logic       rdy_frame;
      logic       rdy_stop;
      logic [7:0] exp_dout;
      logic       exp_valid;
      logic       exp_ferr;
      logic       exp_perr;
      logic       exp_ovr;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Present one bit for one clock edge, return 1 time unit after the edge
   task automatic drive(input logic b, input logic v);
      sin       = b;
      sin_valid = v;
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] data, input logic stop, input logic par,
                             input logic gap, input logic rdy_frame, input logic rdy_stop);
      dout_ready = rdy_frame;
      drive(1'b0, 1'b1);
      if (gap) drive(1'b1, 1'b0);
      for (int i = 0; i < WIDTH; i++) begin
         drive(data[i], 1'b1);
         if (gap) drive(1'b0, 1'b0);
      end
`ifdef JDESER_PARITY_EN
      drive(par, 1'b1);
      if (gap) drive(1'b0, 1'b0);
`else
      if (par) begin end
`endif
      dout_ready = rdy_stop;
      drive(stop, 1'b1);
      sin_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //           data   stop par  gap  rdyF rdyS  dout  vld  ferr perr ovr
      vecs.push_back('{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{8'hF0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{8'h81, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0});
`ifdef JDESER_PARITY_EN
      vecs.push_back('{8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0});
`endif

      rst        = 1'b1;
      sin        = 1'b1;
      sin_valid  = 1'b0;
      dout_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset dout",       32'(dout),       32'h0);
      check("reset dout_valid", 32'(dout_valid), 32'h0);
      check("reset busy",       32'(busy),       32'h0);
      check("reset pulses",     32'({frame_err, parity_err, overrun}), 32'h0);
      rst = 1'b0;
      drive(1'b1, 1'b0);

      // Table-driven frames
      foreach (vecs[k]) begin
         send_frame(vecs[k].data, vecs[k].stop, vecs[k].par, vecs[k].gap,
                    vecs[k].rdy_frame, vecs[k].rdy_stop);
         check($sformatf("v%0d dout", k),       32'(dout),       32'(vecs[k].exp_dout));
         check($sformatf("v%0d dout_valid", k), 32'(dout_valid), 32'(vecs[k].exp_valid));
         check($sformatf("v%0d frame_err", k),  32'(frame_err),  32'(vecs[k].exp_ferr));
         check($sformatf("v%0d parity_err", k), 32'(parity_err), 32'(vecs[k].exp_perr));
         check($sformatf("v%0d overrun", k),    32'(overrun),    32'(vecs[k].exp_ovr));
         check($sformatf("v%0d busy", k),       32'(busy),       32'h0);
         // One idle cycle with the consumer stalled: pulses end, slot is held
         dout_ready = 1'b0;
         drive(1'b1, 1'b0);
         check($sformatf("v%0d pulses end", k), 32'({frame_err, parity_err, overrun}), 32'h0);
         check($sformatf("v%0d valid held", k), 32'(dout_valid), 32'(vecs[k].exp_valid));
         check($sformatf("v%0d dout held", k),  32'(dout),       32'(vecs[k].exp_dout));
      end

      // Handshake drains the held word
      dout_ready = 1'b1;
      drive(1'b1, 1'b0);
      check("drain valid", 32'(dout_valid), 32'h0);

      // Idle-level bits are not start bits
      drive(1'b1, 1'b1);
      drive(1'b1, 1'b1);
      check("idle ones busy", 32'(busy), 32'h0);

      // Gapped frame 8'hF0: busy covers exactly the qualified-bit window
      dout_ready = 1'b1;
      drive(1'b0, 1'b0);
      check("gap pre-start busy", 32'(busy), 32'h0);
      drive(1'b0, 1'b1);
      check("gap start busy", 32'(busy), 32'h1);
      for (int i = 0; i < WIDTH; i++) begin
         drive(1'b1, 1'b0);
         drive(i >= 4 ? 1'b1 : 1'b0, 1'b1);
      end
`ifdef JDESER_PARITY_EN
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b1);
`endif
      drive(1'b0, 1'b0);
      check("gap before stop busy", 32'(busy), 32'h1);
      check("gap before stop valid", 32'(dout_valid), 32'h0);
      drive(1'b1, 1'b1);
      check("gap stop busy", 32'(busy), 32'h0);
      check("gap dout", 32'(dout), 32'hF0);
      check("gap valid", 32'(dout_valid), 32'h1);
      drive(1'b1, 1'b0);
      check("gap valid one cycle", 32'(dout_valid), 32'h0);

      // Back-to-back frames: start bit on the cycle after the stop bit
      send_frame(8'h12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      check("b2b first dout", 32'(dout), 32'h12);
      send_frame(8'h34, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      check("b2b second dout", 32'(dout), 32'h34);
      check("b2b second valid", 32'(dout_valid), 32'h1);

      // Reset after 4 data bits: outputs clear without waiting for an edge
      dout_ready = 1'b0;
      drive(1'b0, 1'b1);
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b1);
      check("pre-reset busy", 32'(busy), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      check("async reset valid", 32'(dout_valid), 32'h0);
      check("async reset busy",  32'(busy),       32'h0);
      check("async reset dout",  32'(dout),       32'h0);
      check("async reset pulses", 32'({frame_err, parity_err, overrun}), 32'h0);
      @(posedge clk);
      #3;
      rst = 1'b0;
      drive(1'b1, 1'b0);
      check("post-reset pulses", 32'({frame_err, parity_err, overrun}), 32'h0);
      send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      check("post-reset dout",  32'(dout),       32'h81);
      check("post-reset valid", 32'(dout_valid), 32'h1);
      check("post-reset errs",  32'({frame_err, parity_err, overrun}), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule : tb_jdeserializer
`default_nettype wire
